// File: rtl/dmem_if.sv
// Request/response bundle between the pipeline MEM stage and the data-memory responder.
interface dmem_if;
  logic        req;
  logic        memWr;
  logic [31:0] addr;
  logic [31:0] wData;
  logic [1:0]  dSize;
  logic        busy;
  logic        ready;
  logic [31:0] rData;
  logic        err;

  modport master (output req, memWr, addr, wData, dSize,
                  input  busy, ready, rData, err);
  modport slave  (input  req, memWr, addr, wData, dSize,
                  output busy, ready, rData, err);
endinterface

// File: rtl/dmem_port.sv
// Multi-cycle big-endian data memory: the access happens at the acceptance edge and the
// response is presented LATENCY cycles later, one request in flight at a time.
module dmem_port #(
  parameter int SIZE    = 16384,
  parameter int LATENCY = 2
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int AW = $clog2(SIZE);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt;
  logic            accept;
  logic            fault;
  logic [AW-1:0]   i0, i1, i2, i3;
  logic [31:0]     rd;
  logic [31:0]     res_data;
  logic            res_err;
  logic [7:0]      mem [0:SIZE-1];

  function automatic logic [2:0] nbytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic fault_of(input logic [31:0] a, input logic [1:0] sz);
    logic [32:0] last;
    last = {1'b0, a} + 33'(nbytes(sz));
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
           (sz == 2'b10 && a[1:0] != 2'b00) || (last > 33'(SIZE));
  endfunction

  // Gating with rst keeps a request held during reset from touching the array.
  assign accept = (state == IDLE) && bus.req && rst;
  assign fault  = fault_of(bus.addr, bus.dSize);
  assign i0     = bus.addr[AW-1:0];
  assign i1     = i0 + AW'(1);
  assign i2     = i0 + AW'(2);
  assign i3     = i0 + AW'(3);

  always_comb begin
    rd = '0;
    if (!fault && !bus.memWr) begin
      case (bus.dSize)
        2'b00:   rd = {24'h0, mem[i0]};
        2'b01:   rd = {16'h0, mem[i0], mem[i1]};
        2'b10:   rd = {mem[i0], mem[i1], mem[i2], mem[i3]};
        default: rd = '0;
      endcase
    end
  end

  // Array and captured result carry no reset: stores survive reset, outputs are gated by ready.
  always_ff @(posedge clk) begin
    if (accept && bus.memWr && !fault) begin
      case (bus.dSize)
        2'b00: mem[i0] <= bus.wData[7:0];
        2'b01: begin
          mem[i0] <= bus.wData[15:8];
          mem[i1] <= bus.wData[7:0];
        end
        2'b10: begin
          mem[i0] <= bus.wData[31:24];
          mem[i1] <= bus.wData[23:16];
          mem[i2] <= bus.wData[15:8];
          mem[i3] <= bus.wData[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      res_data <= rd;
      res_err  <= fault;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= 4'(LATENCY - 1);
      else if (state == WAIT)
        cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state != IDLE);
    bus.ready = (state == RESP);
    bus.rData = (state == RESP) ? res_data : 32'h0;
    bus.err   = (state == RESP) && res_err;
  end
endmodule
